// File: rtl/montred_issue_arbiter.sv
// rtl/montred_issue_arbiter.sv - round-robin, credit-gated issue arbiter for a shared Montgomery-reduction pipe
// Define MONTRED_ISSUE_STATS_EN to add per-requester grant counters and a credit-stall counter.
module montred_issue_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int NUM_PRIMES = 8,
    parameter int PIDX_W     = 3,
    parameter int M          = 17,
    parameter int T_BITS     = 108,
    parameter int OUT_BITS   = 55,
    parameter int PIPE_LAT   = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int SRC_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cfg_we,
    input  logic [PIDX_W-1:0]         cfg_idx,
    input  logic [M-1:0]              cfg_qm,
    input  logic [3:0]                cfg_k,
    output logic                      cfg_err,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*T_BITS-1:0] req_data,
    input  logic [NUM_REQ*PIDX_W-1:0] req_prime,
    output logic [T_BITS-1:0]         stage_in,
    output logic [M-1:0]              stage_q_m,
    output logic [3:0]                stage_k,
    input  logic [OUT_BITS-1:0]       stage_result,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [OUT_BITS-1:0]       res_data,
    output logic [SRC_W-1:0]          res_src,
    output logic [PIDX_W-1:0]         res_prime
`ifdef MONTRED_ISSUE_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]     stat_grants,
    output logic [15:0]               stat_stall
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic              v;
        logic [SRC_W-1:0]  src;
        logic [PIDX_W-1:0] prime;
    } tok_t;

    typedef struct packed {
        logic [OUT_BITS-1:0] data;
        logic [SRC_W-1:0]    src;
        logic [PIDX_W-1:0]   prime;
    } ent_t;

    logic [M-1:0]        cfg_qm_q [NUM_PRIMES];
    logic [M-1:0]        cfg_qm_d [NUM_PRIMES];
    logic [3:0]          cfg_k_q  [NUM_PRIMES];
    logic [3:0]          cfg_k_d  [NUM_PRIMES];
    logic                cfg_err_q, cfg_err_d;
    logic [SRC_W-1:0]    rr_q, rr_d;
    logic [CNT_W-1:0]    occ_q, occ_d;
    logic [T_BITS-1:0]   stage_in_q, stage_in_d;
    logic [M-1:0]        stage_qm_q, stage_qm_d;
    logic [3:0]          stage_k_q, stage_k_d;
    tok_t                tok_q [PIPE_LAT+1];
    tok_t                tok_d [PIPE_LAT+1];
    ent_t                mem_q [FIFO_DEPTH];
    ent_t                mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    mem_cnt_q, mem_cnt_d;
    ent_t                head_q, head_d;
    logic                head_v_q, head_v_d;

    logic                found, issue_ok, hs, pop, fifo_wr, mem_wr, mem_rd, bypass;
    logic [SRC_W-1:0]    gnt;
    logic [SRC_W:0]      cand;
    logic [T_BITS-1:0]   sel_data;
    logic [PIDX_W-1:0]   sel_prime;
    ent_t                wr_ent;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Search starts one past the last granted requester.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        cand  = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = {1'b0, rr_q} + (SRC_W+1)'(off);
            if (cand >= (SRC_W+1)'(NUM_REQ)) cand = cand - (SRC_W+1)'(NUM_REQ);
            if (!found && req_valid[cand[SRC_W-1:0]]) begin
                found = 1'b1;
                gnt   = cand[SRC_W-1:0];
            end
        end
        sel_data  = '0;
        sel_prime = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt == SRC_W'(i)) begin
                sel_data  = req_data[i*T_BITS +: T_BITS];
                sel_prime = req_prime[i*PIDX_W +: PIDX_W];
            end
        end
        issue_ok  = rst_n && (occ_q < CNT_W'(FIFO_DEPTH));
        hs        = found && issue_ok;
        req_ready = hs ? (NUM_REQ'(1) << gnt) : '0;
    end

    always_comb begin
        cfg_qm_d   = cfg_qm_q;
        cfg_k_d    = cfg_k_q;
        cfg_err_d  = cfg_err_q;
        rr_d       = rr_q;
        stage_in_d = stage_in_q;
        stage_qm_d = stage_qm_q;
        stage_k_d  = stage_k_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        head_d     = head_q;
        head_v_d   = head_v_q;
        mem_wr     = 1'b0;
        mem_rd     = 1'b0;
        bypass     = 1'b0;

        if (cfg_we) begin
            if (cfg_k > 4'd8) begin
                cfg_err_d = 1'b1;
            end else begin
                cfg_qm_d[cfg_idx] = cfg_qm;
                cfg_k_d[cfg_idx]  = cfg_k;
            end
        end

        // Config is sampled from the current table, so a same-cycle write is not seen.
        tok_d[0] = '0;
        if (hs) begin
            stage_in_d = sel_data;
            stage_qm_d = cfg_qm_q[sel_prime];
            stage_k_d  = cfg_k_q[sel_prime];
            rr_d       = gnt;
            tok_d[0]   = '{v: 1'b1, src: gnt, prime: sel_prime};
        end
        for (int d = 1; d <= PIPE_LAT; d++) tok_d[d] = tok_q[d-1];

        fifo_wr = tok_q[PIPE_LAT].v;
        wr_ent  = '{data: stage_result, src: tok_q[PIPE_LAT].src, prime: tok_q[PIPE_LAT].prime};
        pop     = head_v_q && res_ready;
        occ_d   = occ_q + CNT_W'(hs) - CNT_W'(pop);

        // Head register refills from storage first, else straight from the capture path.
        if (!head_v_q || pop) begin
            if (mem_cnt_q != '0) begin
                head_d   = mem_q[rd_ptr_q];
                head_v_d = 1'b1;
                mem_rd   = 1'b1;
            end else if (fifo_wr) begin
                head_d   = wr_ent;
                head_v_d = 1'b1;
                bypass   = 1'b1;
            end else begin
                head_v_d = 1'b0;
            end
        end
        mem_wr = fifo_wr && !bypass;
        if (mem_wr) begin
            mem_d[wr_ptr_q] = wr_ent;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (mem_rd) rd_ptr_d = ptr_inc(rd_ptr_q);
        mem_cnt_d = mem_cnt_q + CNT_W'(mem_wr) - CNT_W'(mem_rd);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PRIMES; i++) begin
                cfg_qm_q[i] <= '0;
                cfg_k_q[i]  <= '0;
            end
            for (int d = 0; d <= PIPE_LAT; d++) tok_q[d] <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            cfg_err_q  <= 1'b0;
            rr_q       <= '0;
            occ_q      <= '0;
            stage_in_q <= '0;
            stage_qm_q <= '0;
            stage_k_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            mem_cnt_q  <= '0;
            head_q     <= '0;
            head_v_q   <= 1'b0;
        end else begin
            cfg_qm_q   <= cfg_qm_d;
            cfg_k_q    <= cfg_k_d;
            tok_q      <= tok_d;
            mem_q      <= mem_d;
            cfg_err_q  <= cfg_err_d;
            rr_q       <= rr_d;
            occ_q      <= occ_d;
            stage_in_q <= stage_in_d;
            stage_qm_q <= stage_qm_d;
            stage_k_q  <= stage_k_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mem_cnt_q  <= mem_cnt_d;
            head_q     <= head_d;
            head_v_q   <= head_v_d;
        end
    end

    a_no_fifo_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(mem_wr && !mem_rd && (mem_cnt_q == CNT_W'(FIFO_DEPTH))));

    assign cfg_err   = cfg_err_q;
    assign stage_in  = stage_in_q;
    assign stage_q_m = stage_qm_q;
    assign stage_k   = stage_k_q;
    assign res_valid = head_v_q;
    assign res_data  = head_q.data;
    assign res_src   = head_q.src;
    assign res_prime = head_q.prime;

`ifdef MONTRED_ISSUE_STATS_EN
    logic [15:0] stat_g_q [NUM_REQ];
    logic [15:0] stat_g_d [NUM_REQ];
    logic [15:0] stat_s_q, stat_s_d;

    always_comb begin
        stat_g_d = stat_g_q;
        stat_s_d = stat_s_q;
        if (hs && stat_g_q[gnt] != 16'hFFFF) stat_g_d[gnt] = stat_g_q[gnt] + 16'd1;
        if ((|req_valid) && rst_n && !issue_ok && stat_s_q != 16'hFFFF) stat_s_d = stat_s_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) stat_g_q[i] <= '0;
            stat_s_q <= '0;
        end else begin
            stat_g_q <= stat_g_d;
            stat_s_q <= stat_s_d;
        end
    end

    always_comb begin
        stat_grants = '0;
        for (int i = 0; i < NUM_REQ; i++) stat_grants[i*16 +: 16] = stat_g_q[i];
    end
    assign stat_stall = stat_s_q;
`endif

endmodule

// File: tb/tb_montred_issue_arbiter.sv
// tb/tb_montred_issue_arbiter.sv - randomized + directed bench for montred_issue_arbiter
// Queue-based behavioural model; MONTRED_ISSUE_STATS_EN also checks the stats counters.
module tb_montred_issue_arbiter;
    localparam int N = 4, NP = 8, PW = 3, M = 17, TB = 108, OB = 55, PL = 4, FD = 8, SW = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_we = 1'b0;
    logic [PW-1:0]     cfg_idx = '0;
    logic [M-1:0]      cfg_qm = '0;
    logic [3:0]        cfg_k = '0;
    logic              cfg_err;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N*TB-1:0]   req_data = '0;
    logic [N*PW-1:0]   req_prime = '0;
    logic [TB-1:0]     stage_in;
    logic [M-1:0]      stage_q_m;
    logic [3:0]        stage_k;
    logic [OB-1:0]     stage_result;
    logic              res_valid;
    logic              res_ready = 1'b1;
    logic [OB-1:0]     res_data;
    logic [SW-1:0]     res_src;
    logic [PW-1:0]     res_prime;
`ifdef MONTRED_ISSUE_STATS_EN
    logic [N*16-1:0]   stat_grants;
    logic [15:0]       stat_stall;
`endif

    montred_issue_arbiter dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_qm(cfg_qm),
        .cfg_k(cfg_k), .cfg_err(cfg_err), .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_prime(req_prime), .stage_in(stage_in), .stage_q_m(stage_q_m),
        .stage_k(stage_k), .stage_result(stage_result), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .res_src(res_src), .res_prime(res_prime)
`ifdef MONTRED_ISSUE_STATS_EN
        , .stat_grants(stat_grants), .stat_stall(stat_stall)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [OB-1:0] dp_f(input logic [TB-1:0] d, input logic [M-1:0] q, input logic [3:0] k);
        return (d[OB-1:0] ^ {d[TB-1:TB-38], q}) + OB'(k);
    endfunction

    // Stand-in datapath: PL register stages behind stage_*.
    logic [OB-1:0] dp_q [PL];
    always @(posedge clk) begin
        dp_q[0] <= dp_f(stage_in, stage_q_m, stage_k);
        for (int i = 1; i < PL; i++) dp_q[i] <= dp_q[i-1];
    end
    assign stage_result = dp_q[PL-1];

    typedef struct {
        logic [OB-1:0] res;
        int            src;
        int            prime;
        int            rdy;
    } op_t;

    op_t            ops[$];
    logic [M-1:0]   m_qm [NP];
    logic [3:0]     m_k  [NP];
    logic           m_err;
    int             m_rr;
    logic [TB-1:0]  m_in;
    logic [M-1:0]   m_sqm;
    logic [3:0]     m_sk;
    int             m_gcnt [N];
    int             m_stall;
    int             cyc = 0;
    int             n_checks = 0;
    int             n_fail = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_clear();
        ops.delete();
        for (int i = 0; i < NP; i++) begin m_qm[i] = '0; m_k[i] = '0; end
        for (int i = 0; i < N; i++) m_gcnt[i] = 0;
        m_err = 0; m_rr = 0; m_in = '0; m_sqm = '0; m_sk = '0; m_stall = 0;
    endtask

    // One clock: compare at the falling edge, advance the model, return just after the rising edge.
    task automatic step();
        int            occ, w, p;
        logic [N-1:0]  er;
        logic          ev;
        logic [TB-1:0] d;
        @(negedge clk);
        if (!rst_n) begin
            chk("rst_res_valid", res_valid, 0);
            chk("rst_req_ready", req_ready, 0);
            chk("rst_stage_in", stage_in, 0);
        end else begin
            occ = ops.size();
            w = -1;
            for (int o = 1; o <= N; o++) if (w < 0 && req_valid[(m_rr + o) % N]) w = (m_rr + o) % N;
            er = '0;
            if (w >= 0 && occ < FD) er[w] = 1'b1;
            ev = (ops.size() > 0) && (ops[0].rdy <= cyc);
            chk("req_ready", req_ready, er);
            chk("stage_in", stage_in, m_in);
            chk("stage_q_m", stage_q_m, m_sqm);
            chk("stage_k", stage_k, m_sk);
            chk("cfg_err", cfg_err, m_err);
            chk("res_valid", res_valid, ev);
            if (ev) begin
                chk("res_data", res_data, ops[0].res);
                chk("res_src", res_src, ops[0].src);
                chk("res_prime", res_prime, ops[0].prime);
                if (res_ready) void'(ops.pop_front());
            end
            if (er != '0) begin
                p = int'(req_prime[w*PW +: PW]);
                d = req_data[w*TB +: TB];
                m_in = d; m_sqm = m_qm[p]; m_sk = m_k[p];
                ops.push_back('{res: dp_f(d, m_qm[p], m_k[p]), src: w, prime: p, rdy: cyc + 2 + PL});
                m_rr = w;
                m_gcnt[w]++;
            end
            if (|req_valid && occ >= FD) m_stall++;
            if (cfg_we) begin
                if (cfg_k > 4'd8) m_err = 1'b1;
                else begin m_qm[cfg_idx] = cfg_qm; m_k[cfg_idx] = cfg_k; end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_req(input int i, input logic v, input logic [TB-1:0] d, input logic [PW-1:0] p);
        req_valid[i] = v;
        req_data[i*TB +: TB] = d;
        req_prime[i*PW +: PW] = p;
    endtask

    function automatic logic [TB-1:0] rnd_data();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[TB-1:0];
    endfunction

    task automatic idle(input int n);
        req_valid = '0;
        cfg_we = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        chk("async_rst_res_valid", res_valid, 0);
        model_clear();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int h;
        logic [TB-1:0] x;
        model_clear();
        step();
        step();
        rst_n = 1'b1;
        chk("reset_res_valid", res_valid, 0);
        chk("reset_stage_q_m", stage_q_m, 0);
        chk("reset_cfg_err", cfg_err, 0);
        idle(2);

        // Config entry 2, single op from requester 1
        cfg_we = 1; cfg_idx = 3'd2; cfg_qm = 17'h1ABCD; cfg_k = 4'd8;
        step();
        cfg_we = 0;
        x = rnd_data();
        set_req(1, 1'b1, x, 3'd2);
        #1;
        chk("s1_ready", req_ready, 4'b0010);
        step();
        req_valid = '0;
        chk("s1_stage_q_m", stage_q_m, 17'h1ABCD);
        chk("s1_stage_k", stage_k, 4'd8);
        chk("s1_stage_in", stage_in, x);
        for (int i = 0; i < 4; i++) step();
        chk("s1_res_valid_early", res_valid, 0);
        step();
        chk("s1_res_valid", res_valid, 1);
        chk("s1_res_src", res_src, 2'd1);
        chk("s1_res_prime", res_prime, 3'd2);
        chk("s1_res_data", res_data, dp_f(x, 17'h1ABCD, 4'd8));
        idle(3);

        // Park the pointer on 3, then all four compete
        set_req(3, 1'b1, rnd_data(), 3'd0);
        step();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, rnd_data(), PW'($urandom_range(0, NP-1)));
        for (int k = 0; k < 12; k++) begin
            #1;
            chk("rr_order", req_ready, 4'b0001 << (k % 4));
            for (int i = 0; i < N; i++) set_req(i, 1'b1, rnd_data(), PW'($urandom_range(0, NP-1)));
            step();
        end
        idle(12);

        // Credit limit with the consumer stalled
        res_ready = 0;
        h = 0;
        for (int k = 0; k < 16; k++) begin
            set_req(0, 1'b1, rnd_data(), PW'(k % NP));
            #1;
            if (req_ready[0]) h++;
            step();
        end
        chk("credit_handshakes", h, 8);
        #1;
        chk("credit_ready_low", req_ready, 0);
        h = 0;
        res_ready = 1;
        #1;
        if (req_ready[0]) h++;
        step();
        res_ready = 0;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (req_ready[0]) h++;
            step();
        end
        chk("credit_one_more", h, 1);
        res_ready = 1;
        idle(16);

        // Same-cycle config write vs issue; rejected k
        cfg_we = 1; cfg_idx = 3'd3; cfg_qm = 17'h00111; cfg_k = 4'd1;
        step();
        cfg_qm = 17'h0BEEF; cfg_k = 4'd2;
        set_req(2, 1'b1, rnd_data(), 3'd3);
        step();
        cfg_we = 0;
        chk("cfg_old_qm", stage_q_m, 17'h00111);
        chk("cfg_old_k", stage_k, 4'd1);
        set_req(2, 1'b1, rnd_data(), 3'd3);
        step();
        req_valid = '0;
        chk("cfg_new_qm", stage_q_m, 17'h0BEEF);
        cfg_we = 1; cfg_qm = 17'h1FFFF; cfg_k = 4'd9;
        step();
        cfg_we = 0;
        chk("cfg_err_set", cfg_err, 1);
        set_req(2, 1'b1, rnd_data(), 3'd3);
        step();
        req_valid = '0;
        chk("cfg_unchanged_qm", stage_q_m, 17'h0BEEF);
        chk("cfg_unchanged_k", stage_k, 4'd2);
        idle(12);

        // Reset with ops both in the pipe and in the FIFO
        res_ready = 0;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < N; i++) set_req(i, 1'b1, rnd_data(), PW'($urandom_range(0, NP-1)));
            step();
        end
        idle(2);
        chk("pre_rst_res_valid", res_valid, 1);
        pulse_reset();
        chk("post_rst_cfg_err", cfg_err, 0);
        h = 0;
        for (int k = 0; k < 14; k++) begin
            set_req(0, 1'b1, rnd_data(), PW'(k % NP));
            #1;
            if (req_ready[0]) h++;
            step();
        end
        chk("post_rst_credit", h, 8);
        res_ready = 1;
        idle(16);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < N; i++)
                set_req(i, ($urandom_range(0, 99) < 60), rnd_data(), PW'($urandom_range(0, NP-1)));
            res_ready = ($urandom_range(0, 99) < 65);
            cfg_we = ($urandom_range(0, 99) < 10);
            cfg_idx = PW'($urandom_range(0, NP-1));
            cfg_qm = M'($urandom);
            cfg_k = 4'($urandom_range(0, 9));
            step();
        end
        cfg_we = 0;
        req_valid = '0;
        res_ready = 1;
        idle(20);
        chk("drained", res_valid, 0);

`ifdef MONTRED_ISSUE_STATS_EN
        for (int i = 0; i < N; i++) chk("stat_grants", stat_grants[i*16 +: 16], 16'(m_gcnt[i]));
        chk("stat_stall", stat_stall, 16'(m_stall));
        pulse_reset();
        for (int k = 0; k < 10; k++) begin
            set_req(2, 1'b1, rnd_data(), 3'd1);
            step();
        end
        req_valid = '0;
        idle(14);
        res_ready = 0;
        for (int k = 0; k < 13; k++) begin
            set_req(0, 1'b1, rnd_data(), 3'd0);
            step();
        end
        req_valid = '0;
        chk("stat_g2_ten", stat_grants[2*16 +: 16], 16'd10);
        chk("stat_stall_five", stat_stall, 16'd5);
        res_ready = 1;
        idle(12);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/montred_issue_arbiter.md
Name: montred_issue_arbiter

Overview:
- Shares one pipelined Montgomery-reduction datapath (chain of reduction stages, fixed latency) between NUM_REQ requesters.
- Holds a per-prime configuration table (q_m, current_k).
- Round-robin arbitrates valid/ready requests and drives the datapath inputs with the selected prime's config.
- Tracks tokens (source id, prime index) alongside the fixed-latency pipe; buffers results in an output FIFO protected by credit-based issue, so the datapath never stalls.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- NUM_PRIMES, 8, config table entries
- PIDX_W, 3, prime index width, = clog2(NUM_PRIMES)
- M, 17, q_m width
- T_BITS, 108, reduction input width
- OUT_BITS, 55, datapath result width
- PIPE_LAT, 4, datapath latency in cycles, stage_in to stage_result
- FIFO_DEPTH, 8, result FIFO entries (>= PIPE_LAT+1)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_we  in  1  config write strobe
- cfg_idx  in  PIDX_W  entry written
- cfg_qm  in  M  q_m value
- cfg_k  in  4  current_k (0->46 ... 8->54)
- cfg_err  out  1  sticky; set when cfg_k > 8 is written
- req_valid  in  NUM_REQ  per-requester valid
- req_ready  out  NUM_REQ  per-requester ready (one-hot or zero)
- req_data  in  NUM_REQ*T_BITS  packed operands, requester i at [i*T_BITS +: T_BITS]
- req_prime  in  NUM_REQ*PIDX_W  packed prime indices
- stage_in  out  T_BITS  datapath operand
- stage_q_m  out  M  datapath q_m
- stage_k  out  4  datapath current_k
- stage_result  in  OUT_BITS  datapath result
- res_valid  out  1  FIFO head valid
- res_ready  in  1  consumer accept
- res_data  out  OUT_BITS  result
- res_src  out  clog2(NUM_REQ)  originating requester
- res_prime  out  PIDX_W  prime index used

Behaviour:
- Reset (async, rst_n=0):
  - All config entries: q_m=0, k=0.
  - cfg_err=0; token pipe cleared; FIFO empty; credit count 0; RR pointer=0.
  - Outputs: res_valid=0, req_ready=0, stage_in/q_m/k=0.
  - Reset mid-operation discards all in-flight tokens and FIFO contents; a result arriving after reset is ignored because its token valid is 0.
- Config:
  - cfg_we with cfg_k<=8 writes the entry on the clock edge.
  - cfg_k>8: write dropped, cfg_err set; cfg_err clears only on reset.
  - Config is read at issue and registered with the operand, so in-flight operations are unaffected by later writes.
  - A write to the same index in the same cycle as an issue: the issue uses the old value.
- Credit:
  - occ = tokens in pipe + FIFO count.
  - Issue allowed iff occ < FIFO_DEPTH.
  - Issue and pop in the same cycle: occ unchanged.
- Arbitration:
  - Round-robin; the search starts at the requester after the last granted one.
  - req_ready[g]=1 only for the winner g, only when issue is allowed; otherwise all 0. req_ready is combinational from req_valid, RR pointer and occ.
  - Handshake = req_valid[g] & req_ready[g]. The RR pointer advances to g only on a handshake.
- Issue register:
  - On handshake, on the next edge: stage_in = req_data[g]; stage_q_m/stage_k = cfg[req_prime[g]].
  - Token {valid=1, src=g, prime} enters the token shift register of depth PIPE_LAT.
  - Without a handshake, stage_* hold their previous values and a token with valid=0 is shifted in.
- Capture:
  - When the token at pipe depth PIPE_LAT is valid, stage_result is written to the FIFO with its src and prime.
  - Handshake to FIFO write: 1+PIPE_LAT cycles. res_valid rises one cycle after the FIFO write (earliest 2+PIPE_LAT cycles after handshake).
- FIFO:
  - Circular, pointers wrap at FIFO_DEPTH; first-word-fall-through registered head.
  - Pop on res_valid & res_ready.
  - Overflow is impossible by the credit rule; an assertion checks it.
- Throughput: one issue per cycle sustained while res_ready=1.

Optional Feature:
- Macro: MONTRED_ISSUE_STATS_EN.
- When defined:
  - Adds output stat_grants (NUM_REQ*16): per-requester saturating grant counters.
  - Adds output stat_stall (16): saturating count of cycles with any req_valid=1 but issue blocked by credit.
  - All counters reset to 0.
- When undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, write cfg idx2 q_m=0x1ABCD k=8; requester 1 sends prime 2 data X -> stage_q_m=0x1ABCD, stage_k=8 one cycle after handshake; res_valid at cycle 2+PIPE_LAT=6 with res_src=1, res_prime=2.
- All 4 requesters valid continuously, res_ready=1 -> grants 0,1,2,3,0,...; one issue per cycle; results in grant order.
- res_ready=0, requester 0 streams -> exactly 8 handshakes, then req_ready=0. One pop -> exactly one more grant.
- Config write of idx 3 in the same cycle as an issue using prime 3 -> that op uses the old q_m, the next uses the new one. cfg_k=9 -> entry unchanged, cfg_err=1.
- rst_n low for 1 cycle with 3 ops in the pipe and 2 in the FIFO -> res_valid=0 immediately, no stale result afterwards, credit fully restored (8 new issues accepted).
- With MONTRED_ISSUE_STATS_EN, 10 grants to requester 2 and 5 credit-blocked cycles -> stat_grants[2]=10, stat_stall=5.
